ball_motion: RTL and testbench

- Game-side producer of the ball sprite position consumed by the display pipeline.
- Advances the ball once per frame on the display's new-frame pulse.
- Bounces the ball off the top/bottom walls and both paddles.
- On a miss, issues a one-cycle score pulse, re-centres the ball and waits a serve delay before relaunching.

---
 rtl/display_pkg.sv | 7 +
 rtl/sprite_pkg.sv | 13 +
 rtl/paddle_hit.sv | 37 +++
 rtl/ball_motion.sv | 164 ++++++++++++++++
 tb/tb_ball_motion.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/display_pkg.sv
// Display timing constants shared by every sprite producer.
package display_pkg;
  localparam int SCREEN_H_RES = 640;
  localparam int SCREEN_V_RES = 480;
  localparam int X_POS_W      = 10;
  localparam int Y_POS_W      = 9;
endpackage

// File: rtl/sprite_pkg.sv
// Sprite geometry, ball dynamics constants and ball control types.
package sprite_pkg;
  typedef enum logic {DIR_NEG, DIR_POS} ball_dir_t;
  typedef enum logic {SERVE, MOVE}      ball_state_t;

  localparam int BALL_SIDE      = 16;
  localparam int PADDLE_WIDTH   = 16;
  localparam int PADDLE_HEIGHT  = 64;
  localparam int LEFT_PADDLE_X  = 32;
  localparam int RIGHT_PADDLE_X = 592;
  localparam int BALL_SPEED     = 4;
  localparam int SERVE_FRAMES   = 60;
endpackage

// File: rtl/paddle_hit.sv
// Combinational paddle contact test: x-edge crossing plus vertical span overlap.
module paddle_hit
  import display_pkg::*;
#(
  parameter bit IS_LEFT       = 1'b1,
  parameter int PADDLE_X      = 32,
  parameter int PADDLE_WIDTH  = 16,
  parameter int PADDLE_HEIGHT = 64,
  parameter int BALL_SIDE     = 16,
  parameter int XS_W          = X_POS_W + 2,
  parameter int YS_W          = Y_POS_W + 2
) (
  input  logic signed [XS_W-1:0] cur_x,
  input  logic signed [XS_W-1:0] next_x,
  input  logic signed [YS_W-1:0] next_y,
  input  logic [YS_W-3:0]        paddle_y,
  output logic                   hit
);
  logic signed [YS_W-1:0] py;
  logic                   span_ok;
  logic                   edge_ok;

  assign py      = $signed({2'b00, paddle_y});
  assign span_ok = (next_y + YS_W'(BALL_SIDE) > py) && (next_y < py + YS_W'(PADDLE_HEIGHT));

  // Left paddle faces right, right paddle faces left: the edge test mirrors.
  generate
    if (IS_LEFT) begin : g_left
      assign edge_ok = (next_x <= XS_W'(PADDLE_X + PADDLE_WIDTH)) && (cur_x > XS_W'(PADDLE_X));
    end else begin : g_right
      assign edge_ok = (next_x + XS_W'(BALL_SIDE) >= XS_W'(PADDLE_X)) &&
                       (cur_x + XS_W'(BALL_SIDE) < XS_W'(PADDLE_X + PADDLE_WIDTH));
    end
  endgenerate

  assign hit = span_ok && edge_ok;
endmodule

// File: rtl/ball_motion.sv
// Ball position producer: serve hold, per-frame motion, wall/paddle bounce, miss scoring.
module ball_motion
  import display_pkg::*;
  import sprite_pkg::*;
#(
  parameter int SCREEN_H_RES   = display_pkg::SCREEN_H_RES,
  parameter int SCREEN_V_RES   = display_pkg::SCREEN_V_RES,
  parameter int BALL_SIDE      = sprite_pkg::BALL_SIDE,
  parameter int PADDLE_WIDTH   = sprite_pkg::PADDLE_WIDTH,
  parameter int PADDLE_HEIGHT  = sprite_pkg::PADDLE_HEIGHT,
  parameter int LEFT_PADDLE_X  = sprite_pkg::LEFT_PADDLE_X,
  parameter int RIGHT_PADDLE_X = sprite_pkg::RIGHT_PADDLE_X,
  parameter int BALL_SPEED     = sprite_pkg::BALL_SPEED,
  parameter int SERVE_FRAMES   = sprite_pkg::SERVE_FRAMES
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               new_frame_i,
  input  logic [Y_POS_W-1:0] left_paddle_y_i,
  input  logic [Y_POS_W-1:0] right_paddle_y_i,
  output logic [X_POS_W-1:0] ball_x_o,
  output logic [Y_POS_W-1:0] ball_y_o,
  output logic               score_left_o,
  output logic               score_right_o,
  output logic               serving_o
);
  localparam int XS_W  = X_POS_W + 2;
  localparam int YS_W  = Y_POS_W + 2;
  localparam int CNT_W = $clog2(SERVE_FRAMES);
  localparam int CX    = (SCREEN_H_RES - BALL_SIDE) / 2;
  localparam int CY    = (SCREEN_V_RES - BALL_SIDE) / 2;

  localparam logic signed [XS_W-1:0] X_ZERO   = '0;
  localparam logic signed [XS_W-1:0] X_STEP   = XS_W'(BALL_SPEED);
  localparam logic signed [XS_W-1:0] X_MISS_R = XS_W'(SCREEN_H_RES - BALL_SIDE);
  localparam logic signed [YS_W-1:0] Y_ZERO   = '0;
  localparam logic signed [YS_W-1:0] Y_STEP   = YS_W'(BALL_SPEED);
  localparam logic signed [YS_W-1:0] Y_MAX    = YS_W'(SCREEN_V_RES - BALL_SIDE);

  ball_state_t        state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [X_POS_W-1:0] x, x_n;
  logic [Y_POS_W-1:0] y, y_n;
  ball_dir_t          dx, dx_n, dy, dy_n;
  logic               score_l, score_l_n, score_r, score_r_n;

  logic signed [XS_W-1:0] x_s, nx;
  logic signed [YS_W-1:0] y_s, ny;
  logic                   left_hit, right_hit;

  // Candidate position one step along the current heading, in signed arithmetic.
  assign x_s = $signed({2'b00, x});
  assign y_s = $signed({2'b00, y});
  assign nx  = (dx == DIR_POS) ? x_s + X_STEP : x_s - X_STEP;
  assign ny  = (dy == DIR_POS) ? y_s + Y_STEP : y_s - Y_STEP;

  paddle_hit #(
    .IS_LEFT(1'b1), .PADDLE_X(LEFT_PADDLE_X), .PADDLE_WIDTH(PADDLE_WIDTH),
    .PADDLE_HEIGHT(PADDLE_HEIGHT), .BALL_SIDE(BALL_SIDE), .XS_W(XS_W), .YS_W(YS_W)
  ) u_left_hit (
    .cur_x(x_s), .next_x(nx), .next_y(ny), .paddle_y(left_paddle_y_i), .hit(left_hit)
  );

  paddle_hit #(
    .IS_LEFT(1'b0), .PADDLE_X(RIGHT_PADDLE_X), .PADDLE_WIDTH(PADDLE_WIDTH),
    .PADDLE_HEIGHT(PADDLE_HEIGHT), .BALL_SIDE(BALL_SIDE), .XS_W(XS_W), .YS_W(YS_W)
  ) u_right_hit (
    .cur_x(x_s), .next_x(nx), .next_y(ny), .paddle_y(right_paddle_y_i), .hit(right_hit)
  );

  // State register: everything updates only when the next-state logic says so.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= SERVE;
      cnt     <= '0;
      x       <= X_POS_W'(CX);
      y       <= Y_POS_W'(CY);
      dx      <= DIR_POS;
      dy      <= DIR_POS;
      score_l <= 1'b0;
      score_r <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      x       <= x_n;
      y       <= y_n;
      dx      <= dx_n;
      dy      <= dy_n;
      score_l <= score_l_n;
      score_r <= score_r_n;
    end
  end

  // Next-state logic: serve countdown, wall clamp, paddle bounce, miss handling.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    x_n       = x;
    y_n       = y;
    dx_n      = dx;
    dy_n      = dy;
    score_l_n = 1'b0;
    score_r_n = 1'b0;
    if (new_frame_i) begin
      case (state)
        SERVE: begin
          if (cnt == CNT_W'(SERVE_FRAMES - 1)) begin
            cnt_n   = '0;
            state_n = MOVE;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        MOVE: begin
          if (ny <= Y_ZERO) begin
            y_n  = '0;
            dy_n = DIR_POS;
          end else if (ny >= Y_MAX) begin
            y_n  = Y_MAX[Y_POS_W-1:0];
            dy_n = DIR_NEG;
          end else begin
            y_n = ny[Y_POS_W-1:0];
          end
          // A paddle hit outranks a miss; a miss re-centres and leaves dy untouched.
          if (dx == DIR_NEG) begin
            if (left_hit) begin
              x_n  = X_POS_W'(LEFT_PADDLE_X + PADDLE_WIDTH);
              dx_n = DIR_POS;
            end else if (nx <= X_ZERO) begin
              score_r_n = 1'b1;
              dx_n      = DIR_NEG;
              state_n   = SERVE;
            end else begin
              x_n = nx[X_POS_W-1:0];
            end
          end else begin
            if (right_hit) begin
              x_n  = X_POS_W'(RIGHT_PADDLE_X - BALL_SIDE);
              dx_n = DIR_NEG;
            end else if (nx >= X_MISS_R) begin
              score_l_n = 1'b1;
              dx_n      = DIR_POS;
              state_n   = SERVE;
            end else begin
              x_n = nx[X_POS_W-1:0];
            end
          end
          if (state_n == SERVE) begin
            x_n  = X_POS_W'(CX);
            y_n  = Y_POS_W'(CY);
            dy_n = dy;
          end
        end
        default: state_n = SERVE;
      endcase
    end
  end

  assign ball_x_o      = x;
  assign ball_y_o      = y;
  assign score_left_o  = score_l;
  assign score_right_o = score_r;
  assign serving_o     = (state == SERVE);
endmodule

// File: tb/tb_ball_motion.sv
// Self-checking bench for ball_motion: reference model + scoreboard + checkpoint table.
module tb_ball_motion;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       new_frame = 1'b0;
  logic [8:0] lp = '0;
  logic [8:0] rp = '0;
  logic [9:0] ball_x;
  logic [8:0] ball_y;
  logic       score_l, score_r, serving;

  ball_motion dut (
    .clk_i(clk), .rst_i(rst), .new_frame_i(new_frame),
    .left_paddle_y_i(lp), .right_paddle_y_i(rp),
    .ball_x_o(ball_x), .ball_y_o(ball_y),
    .score_left_o(score_l), .score_right_o(score_r), .serving_o(serving)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    bit srv;
    bit sl;
    bit sr;
  } exp_t;

  typedef struct {
    int pulse;
    int x;
    int y;
    bit srv;
  } ckpt_t;

  exp_t  sbq[$];
  ckpt_t tbl[16];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    pulse_cnt = 0;
  int    mode = 0;
  int    lp_v, rp_v;

  // Reference model state
  int mx, my, mdx, mdy, mcnt;
  bit mserve, msl, msr;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (pulse %0d)", name, act, exp, pulse_cnt);
    end
  endtask

  task automatic model_reset();
    mx = 312; my = 232; mdx = 1; mdy = 1; mcnt = 0;
    mserve = 1; msl = 0; msr = 0;
  endtask

  task automatic model_step(input int l, input int r);
    int nx, ny, ty, tdy;
    bit miss;
    msl = 0; msr = 0;
    if (mserve) begin
      if (mcnt == 59) begin mcnt = 0; mserve = 0; end
      else mcnt++;
    end else begin
      nx = mx + 4 * mdx;
      ny = my + 4 * mdy;
      ty = ny; tdy = mdy; miss = 0;
      if (ny <= 0) begin ty = 0; tdy = 1; end
      else if (ny >= 464) begin ty = 464; tdy = -1; end
      if (mdx < 0) begin
        if (nx <= 48 && mx > 32 && ny + 16 > l && ny < l + 64) begin mx = 48; mdx = 1; end
        else if (nx <= 0) begin msr = 1; miss = 1; mdx = -1; end
        else mx = nx;
      end else begin
        if (nx + 16 >= 592 && mx + 16 < 608 && ny + 16 > r && ny < r + 64) begin mx = 576; mdx = -1; end
        else if (nx >= 624) begin msl = 1; miss = 1; mdx = 1; end
        else mx = nx;
      end
      if (miss) begin mx = 312; my = 232; mserve = 1; end
      else begin my = ty; mdy = tdy; end
    end
  endtask

  // Paddle placement: 0 = both track the ball, 1 = left dodges, right tracks, 2 = random
  task automatic pick_paddles();
    int trk;
    trk = (my < 24) ? 0 : my - 24;
    case (mode)
      0: begin lp_v = trk; rp_v = trk; end
      1: begin lp_v = (my < 240) ? 400 : 0; rp_v = trk; end
      default: begin lp_v = int'($urandom_range(0, 460)); rp_v = int'($urandom_range(0, 460)); end
    endcase
    lp = 9'(lp_v);
    rp = 9'(rp_v);
  endtask

  task automatic compare_out(input string tag, input exp_t e);
    check({tag, "_x"}, int'(ball_x), e.x);
    check({tag, "_y"}, int'(ball_y), e.y);
    check({tag, "_serving"}, int'(serving), int'(e.srv));
    check({tag, "_score_l"}, int'(score_l), int'(e.sl));
    check({tag, "_score_r"}, int'(score_r), int'(e.sr));
  endtask

  // n back-to-back frame pulses, then one idle cycle where outputs must hold
  task automatic frame_pulse(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      pick_paddles();
      new_frame = 1'b1;
      model_step(lp_v, rp_v);
      e.x = mx; e.y = my; e.srv = mserve; e.sl = msl; e.sr = msr;
      sbq.push_back(e);
      @(posedge clk); #1;
      e = sbq.pop_front();
      compare_out("pulse", e);
      pulse_cnt++;
    end
    new_frame = 1'b0;
    @(posedge clk); #1;
    e.x = mx; e.y = my; e.srv = mserve; e.sl = 0; e.sr = 0;
    compare_out("hold", e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    check("rst_x", int'(ball_x), 312);
    check("rst_y", int'(ball_y), 232);
    check("rst_serving", int'(serving), 1);
    check("rst_score", int'({score_l, score_r}), 0);
  endtask

  initial begin
    int guard;
    bit missed;
    // Opening trajectory with tracking paddles, values derived by hand
    tbl[0]  = '{0,    312, 232, 1'b1};
    tbl[1]  = '{59,   312, 232, 1'b1};
    tbl[2]  = '{60,   312, 232, 1'b0};
    tbl[3]  = '{61,   316, 236, 1'b0};
    tbl[4]  = '{118,  544, 464, 1'b0};
    tbl[5]  = '{119,  548, 460, 1'b0};
    tbl[6]  = '{126,  576, 432, 1'b0};
    tbl[7]  = '{127,  572, 428, 1'b0};
    tbl[8]  = '{234,  144, 0,   1'b0};
    tbl[9]  = '{235,  140, 4,   1'b0};
    tbl[10] = '{258,  48,  96,  1'b0};
    tbl[11] = '{259,  52,  100, 1'b0};
    tbl[12] = '{1973, 572, 460, 1'b0};
    tbl[13] = '{1974, 576, 464, 1'b0};
    tbl[14] = '{1975, 572, 460, 1'b0};
    tbl[15] = '{1976, 568, 456, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    do_reset();

    for (int i = 0; i < 16; i++) begin
      while (pulse_cnt < tbl[i].pulse) frame_pulse(1);
      check("tbl_x", int'(ball_x), tbl[i].x);
      check("tbl_y", int'(ball_y), tbl[i].y);
      check("tbl_serving", int'(serving), int'(tbl[i].srv));
    end

    // Left paddle dodges: ball runs out on the left, right player scores
    mode = 1;
    guard = 0;
    missed = 0;
    while (!missed && guard < 400) begin
      frame_pulse(1);
      guard++;
      if (msr) missed = 1;
    end
    check("left_miss_seen", int'(missed), 1);
    check("miss_x", int'(ball_x), 312);
    check("miss_y", int'(ball_y), 232);
    check("miss_serving", int'(serving), 1);
    repeat (60) frame_pulse(1);
    check("serve_done", int'(serving), 0);
    check("serve_done_x", int'(ball_x), 312);
    frame_pulse(1);
    check("relaunch_x1", int'(ball_x), 308);
    frame_pulse(1);
    check("relaunch_x2", int'(ball_x), 304);

    // Consecutive-cycle frame pulses are separate updates
    frame_pulse(3);

    // Random paddles
    mode = 2;
    repeat (400) frame_pulse(1);

    // Reset while moving
    mode = 0;
    guard = 0;
    while (mserve && guard < 100) begin frame_pulse(1); guard++; end
    check("in_move_before_rst", int'(serving), 0);
    do_reset();

    // Reset mid-serve, then the full serve count must start over
    repeat (30) frame_pulse(1);
    do_reset();
    repeat (59) frame_pulse(1);
    check("serve59_serving", int'(serving), 1);
    frame_pulse(1);
    check("serve60_serving", int'(serving), 0);
    frame_pulse(1);
    check("serve61_x", int'(ball_x), 316);
    check("serve61_y", int'(ball_y), 236);

    check("sb_empty", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
